// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, half-bit timing, idle line level.
package uart_pkg;

  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high serial line; resets to the idle level so
// no false start bit is seen coming out of reset.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= UART_IDLE_LVL;
      rx_s <= UART_IDLE_LVL;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: mid-bit sampling of start/data[/parity]/stop into a valid/ready holding register.
// Optional parity bit is built when UART_RX_PARITY_EN is defined.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 rx_busy,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int HALF   = half_bit(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int DCNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DCNT_W-1:0]    data_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 deliver_pend;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic parity_bad;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  assign rx_busy = (state != IDLE);

  // The completed frame is handed to the holding register one cycle after the stop
  // sample, so the framer itself never waits on the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      data_cnt     <= '0;
      shift_reg    <= '0;
      deliver_pend <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      framing_err  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      framing_err  <= 1'b0;
      overrun      <= 1'b0;
      deliver_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif

      if (deliver_pend) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_s != UART_IDLE_LVL) begin
            state    <= START;
            bit_cnt  <= '0;
            data_cnt <= '0;
          end
        end

        // A start bit that is high again at its midpoint was a glitch.
        START: begin
          if (bit_cnt == CNT_HALF) begin
            bit_cnt <= '0;
            state   <= (rx_s == UART_IDLE_LVL) ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (data_cnt == DCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              data_cnt <= data_cnt + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt    <= '0;
            parity_bad <= (rx_s != ((^shift_reg) ^ ODD_BIT));
            state      <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (rx_s != UART_IDLE_LVL) begin
              framing_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
`ifdef UART_RX_PARITY_EN
            else if (parity_bad) begin
              parity_err <= 1'b1;
              state      <= IDLE;
            end
`endif
            else begin
              deliver_pend <= 1'b1;
              state        <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        // A held-low line (break) must return high before a new start is looked for.
        WAIT_IDLE: begin
          if (rx_s == UART_IDLE_LVL) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 4 clocks per bit; parity cases run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_framer;

  localparam int CPB = 4;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       rx_busy;
  logic       framing_err;
  logic       parity_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  int valid_cycles = 0;
  int acc_cnt      = 0;
  int fe_cnt       = 0;
  int pe_cnt       = 0;
  int ov_cnt       = 0;
  int busy_cycles  = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] acc_byte  = 8'h00;

  int b_valid, b_acc, b_fe, b_pe, b_ov, b_busy;

  uart_rx_framer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .PARITY_ODD   (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .rx_busy     (rx_busy),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Outputs are observed on the falling edge, inputs change 2 ns after the rising edge.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cycles++;
      last_data = data_out;
    end
    if (data_valid && data_ready) begin
      acc_cnt++;
      acc_byte = data_out;
    end
    if (framing_err) fe_cnt++;
    if (parity_err)  pe_cnt++;
    if (overrun)     ov_cnt++;
    if (rx_busy)     busy_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic snap();
    b_valid = valid_cycles;
    b_acc   = acc_cnt;
    b_fe    = fe_cnt;
    b_pe    = pe_cnt;
    b_ov    = ov_cnt;
    b_busy  = busy_cycles;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    tick(CPB);
`else
    if (par_bit === 1'bx) $display("[TB] note: parity bit undefined");
`endif
    rx = stop_bit;
    tick(CPB);
  endtask

  initial begin
    reset      = 1'b0;
    rx         = 1'b1;
    data_ready = 1'b0;
    tick(3);
    checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("rst_data",  {24'd0, data_out},   32'd0);
    checkOutput("rst_busy",  {31'd0, rx_busy},    32'd0);
    checkOutput("rst_errs",  {29'd0, framing_err, parity_err, overrun}, 32'd0);
    reset = 1'b1;
    tick(8);

    // 1: single frame, consumer ready
    $display("[TB] test 1: frame 0x55");
    data_ready = 1'b1;
    snap();
    applyStimulus(8'h55, 1'b1, 1'b0);
    tick(16);
    checkOutput("t1_valid_cycles", valid_cycles - b_valid, 1);
    checkOutput("t1_data",         {24'd0, last_data}, 32'h55);
    checkOutput("t1_errs",         (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);
    checkOutput("t1_busy",         {31'd0, rx_busy}, 32'd0);

    // 2: overrun while holding register is full
    $display("[TB] test 2: overrun");
    data_ready = 1'b0;
    snap();
    applyStimulus(8'h3C, 1'b1, 1'b0);
    tick(4);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    tick(16);
    checkOutput("t2_overrun",   ov_cnt - b_ov, 1);
    checkOutput("t2_data_held", {24'd0, data_out}, 32'h3C);
    checkOutput("t2_valid",     {31'd0, data_valid}, 32'd1);
    checkOutput("t2_no_accept", acc_cnt - b_acc, 0);
    data_ready = 1'b1;
    tick(1);
    checkOutput("t2_valid_clear", {31'd0, data_valid}, 32'd0);
    checkOutput("t2_accept_cnt",  acc_cnt - b_acc, 1);
    checkOutput("t2_accept_byte", {24'd0, acc_byte}, 32'h3C);

    // 3: one-clock glitch on rx
    $display("[TB] test 3: glitch");
    tick(8);
    snap();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(4);
    checkOutput("t3_busy_back", {31'd0, rx_busy}, 32'd0);
    checkOutput("t3_busy_cycles", busy_cycles - b_busy, 2);
    tick(8);
    checkOutput("t3_no_valid", valid_cycles - b_valid, 0);
    checkOutput("t3_no_errs",  (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);

    // 4: framing error followed by a long break, then a good frame
    $display("[TB] test 4: framing error and break");
    snap();
    applyStimulus(8'h81, 1'b0, 1'b0);
    rx = 1'b0;
    tick(20 * CPB);
    checkOutput("t4_framing",   fe_cnt - b_fe, 1);
    checkOutput("t4_no_valid",  valid_cycles - b_valid, 0);
    checkOutput("t4_no_parity", pe_cnt - b_pe, 0);
    checkOutput("t4_busy_break", {31'd0, rx_busy}, 32'd1);
    rx = 1'b1;
    tick(8);
    checkOutput("t4_idle_again", {31'd0, rx_busy}, 32'd0);
    applyStimulus(8'h42, 1'b1, 1'b0);
    tick(16);
    checkOutput("t4_data",        {24'd0, last_data}, 32'h42);
    checkOutput("t4_valid_cycles", valid_cycles - b_valid, 1);
    checkOutput("t4_framing_once", fe_cnt - b_fe, 1);

    // 5: reset asserted in the middle of a frame
    $display("[TB] test 5: reset mid-frame");
    snap();
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1; tick(CPB);
    rx = 1'b0; tick(CPB);
    rx = 1'b0; tick(CPB);
    checkOutput("t5_busy_mid", {31'd0, rx_busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t5_rst_data",  {24'd0, data_out}, 32'd0);
    checkOutput("t5_rst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("t5_rst_busy",  {31'd0, rx_busy}, 32'd0);
    checkOutput("t5_rst_errs",  {29'd0, framing_err, parity_err, overrun}, 32'd0);
    rx = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(8);
    snap();
    applyStimulus(8'hF0, 1'b1, 1'b0);
    tick(16);
    checkOutput("t5_data",         {24'd0, last_data}, 32'hF0);
    checkOutput("t5_valid_cycles", valid_cycles - b_valid, 1);
    checkOutput("t5_errs",         (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, 0x07 has three ones so the correct parity bit is 1
    $display("[TB] test 6: parity");
    snap();
    applyStimulus(8'h07, 1'b1, 1'b0);
    tick(16);
    checkOutput("t6_parity_err", pe_cnt - b_pe, 1);
    checkOutput("t6_no_valid",   valid_cycles - b_valid, 0);
    applyStimulus(8'h07, 1'b1, 1'b1);
    tick(16);
    checkOutput("t6_data",       {24'd0, last_data}, 32'h07);
    checkOutput("t6_valid",      valid_cycles - b_valid, 1);
    checkOutput("t6_parity_once", pe_cnt - b_pe, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
